hazard_ctl: RTL and testbench

Parametrised RAW-hazard and pipeline-control unit for the five-stage pipeline, sitting beside the decode stage and driving the PC, IF/ID and ID/EX register controls. It compares the decode instruction's source registers against the destinations in EX, MEM and WB and computes the exact number of bubbles needed, 0 to 3. It holds the stall for that many cycles with a down-counter, then releases, rather than pulsing a single NOP. It also handles taken-branch flush, external freeze, and a saturating stall-cycle performance counter.

---
 rtl/hazard_ctl_pkg.sv | 53 +++++
 rtl/hazard_ctl_need.sv | 55 +++++
 rtl/hazard_ctl.sv | 125 ++++++++++++
 tb/tb_hazard_ctl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctl_pkg.sv
// Shared types and constants for the RAW-hazard / pipeline-control unit.
// Bubble counts are per matching producer stage, selected by forwarding/bypass config.
package hazard_ctl_pkg;

    localparam int REG_W_DEFAULT = 3;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        STG_EX  = 2'd0,
        STG_MEM = 2'd1,
        STG_WB  = 2'd2
    } stage_e;

    localparam logic [1:0] NEED_BYP_EX    = 2'd2;
    localparam logic [1:0] NEED_BYP_MEM   = 2'd1;
    localparam logic [1:0] NEED_BYP_WB    = 2'd0;
    localparam logic [1:0] NEED_NOBYP_EX  = 2'd3;
    localparam logic [1:0] NEED_NOBYP_MEM = 2'd2;
    localparam logic [1:0] NEED_NOBYP_WB  = 2'd1;
    localparam logic [1:0] NEED_LOAD_USE  = 2'd1;

    function automatic logic [1:0] stage_need(input int fwd_en, input int rf_bypass,
                                              input stage_e stage, input logic is_load);
        logic [1:0] n;
        n = 2'd0;
        // With forwarding only a load in EX cannot supply its result in time.
        if (fwd_en != 0) begin
            if ((stage == STG_EX) && is_load) n = NEED_LOAD_USE;
        end else if (rf_bypass != 0) begin
            case (stage)
                STG_EX:  n = NEED_BYP_EX;
                STG_MEM: n = NEED_BYP_MEM;
                default: n = NEED_BYP_WB;
            endcase
        end else begin
            case (stage)
                STG_EX:  n = NEED_NOBYP_EX;
                STG_MEM: n = NEED_NOBYP_MEM;
                default: n = NEED_NOBYP_WB;
            endcase
        end
        return n;
    endfunction

    function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_ctl_need.sv
// Combinational bubble-need calculation: worst case over every source operand
// compared against the EX, MEM and WB destinations.
module hazard_need
    import hazard_ctl_pkg::*;
#(
    parameter int REG_W     = REG_W_DEFAULT,
    parameter int NUM_SRC   = 2,
    parameter int FWD_EN    = 0,
    parameter int RF_BYPASS = 1,
    parameter int ZERO_REG  = 0
) (
    input  logic                     id_vld,
    input  logic [NUM_SRC*REG_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]       id_src_vld,
    input  logic [REG_W-1:0]         ex_dst_addr,
    input  logic [REG_W-1:0]         mem_dst_addr,
    input  logic [REG_W-1:0]         wb_dst_addr,
    input  logic                     ex_wr_en,
    input  logic                     mem_wr_en,
    input  logic                     wb_wr_en,
    input  logic                     ex_is_load,
    output logic [1:0]               need
);

    logic [2*NUM_SRC-1:0] op_need;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
        logic [REG_W-1:0] src;
        logic             live;
        logic [1:0]       ex_n;
        logic [1:0]       mem_n;
        logic [1:0]       wb_n;

        assign src  = id_src_addr[i*REG_W +: REG_W];
        // A hard-wired zero register never carries a real dependency.
        assign live = id_vld && id_src_vld[i] && !((ZERO_REG != 0) && (src == '0));

        assign ex_n  = (live && ex_wr_en && (src == ex_dst_addr))
                       ? stage_need(FWD_EN, RF_BYPASS, STG_EX, ex_is_load) : 2'd0;
        assign mem_n = (live && mem_wr_en && (src == mem_dst_addr))
                       ? stage_need(FWD_EN, RF_BYPASS, STG_MEM, 1'b0) : 2'd0;
        assign wb_n  = (live && wb_wr_en && (src == wb_dst_addr))
                       ? stage_need(FWD_EN, RF_BYPASS, STG_WB, 1'b0) : 2'd0;

        assign op_need[2*i +: 2] = max_need(ex_n, max_need(mem_n, wb_n));
    end

    always_comb begin
        need = 2'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            need = max_need(need, op_need[2*i +: 2]);
        end
    end

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: holds PC/IF-ID and bubbles ID/EX for exactly the
// computed number of cycles, with freeze and taken-branch flush taking priority.
module hazard_ctl
    import hazard_ctl_pkg::*;
#(
    parameter int REG_W     = REG_W_DEFAULT,
    parameter int NUM_SRC   = 2,
    parameter int FWD_EN    = 0,
    parameter int RF_BYPASS = 1,
    parameter int ZERO_REG  = 0,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_vld,
    input  logic [NUM_SRC*REG_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]       id_src_vld,
    input  logic [REG_W-1:0]         ex_dst_addr,
    input  logic [REG_W-1:0]         mem_dst_addr,
    input  logic [REG_W-1:0]         wb_dst_addr,
    input  logic                     ex_wr_en,
    input  logic                     mem_wr_en,
    input  logic                     wb_wr_en,
    input  logic                     ex_is_load,
    input  logic                     br_taken,
    input  logic                     ext_stall,
    output logic                     pc_hold,
    output logic                     ifid_hold,
    output logic                     idex_bubble,
    output logic                     ifid_flush,
    output logic                     pipe_freeze,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic                     dbg_state,
    output logic [1:0]               dbg_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [1:0]       need;

    hazard_need #(
        .REG_W     (REG_W),
        .NUM_SRC   (NUM_SRC),
        .FWD_EN    (FWD_EN),
        .RF_BYPASS (RF_BYPASS),
        .ZERO_REG  (ZERO_REG)
    ) u_need (
        .id_vld       (id_vld),
        .id_src_addr  (id_src_addr),
        .id_src_vld   (id_src_vld),
        .ex_dst_addr  (ex_dst_addr),
        .mem_dst_addr (mem_dst_addr),
        .wb_dst_addr  (wb_dst_addr),
        .ex_wr_en     (ex_wr_en),
        .mem_wr_en    (mem_wr_en),
        .wb_wr_en     (wb_wr_en),
        .ex_is_load   (ex_is_load),
        .need         (need)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_cycles_d = stall_cycles_q;
        pc_hold        = 1'b0;
        ifid_hold      = 1'b0;
        idex_bubble    = 1'b0;
        ifid_flush     = 1'b0;
        pipe_freeze    = 1'b0;

        if (!rst) begin
            // Outputs stay quiet while reset is held, whatever the inputs say.
        end else if (ext_stall) begin
            pipe_freeze = 1'b1;
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
        end else if (br_taken) begin
            // ID holds a wrong-path instruction, so any pending stall is moot.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = RUN;
            cnt_d       = 2'd0;
        end else if (state_q == STALL) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            cnt_d       = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = RUN;
        end else if (need != 2'd0) begin
            // First bubble is issued now; STALL covers the remaining need-1.
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            if (need >= 2'd2) begin
                state_d = STALL;
                cnt_d   = need - 2'd1;
            end
        end

        if (idex_bubble && !ext_stall && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            cnt_q          <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign dbg_state    = state_q;
    assign dbg_cnt      = cnt_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: four parameter variants share one stimulus stream;
// a vector table covers the need calculation, hand sequences cover multi-cycle cases.
module tb_hazard_ctl;

    localparam int Z_CNT_W = 2;

    logic       clk;
    logic       rst;
    logic       id_vld;
    logic [5:0] id_src_addr;
    logic [1:0] id_src_vld;
    logic [2:0] ex_dst_addr, mem_dst_addr, wb_dst_addr;
    logic       ex_wr_en, mem_wr_en, wb_wr_en, ex_is_load, br_taken, ext_stall;

    // Index 0: defaults, 1: no RF bypass, 2: forwarding, 3: zero reg + 2-bit counter.
    logic [3:0]         pc_hold_v, ifid_hold_v, idex_bubble_v, ifid_flush_v, pipe_freeze_v, dbg_state_v;
    logic [1:0]         dbg_cnt_v [4];
    logic [15:0]        sc_def, sc_nb, sc_fwd;
    logic [Z_CNT_W-1:0] sc_z;

    typedef struct {
        logic       vld;
        logic [2:0] s0;
        logic [2:0] s1;
        logic [1:0] sv;
        logic [2:0] exd;
        logic       exw;
        logic [2:0] memd;
        logic       memw;
        logic [2:0] wbd;
        logic       wbw;
        logic       ld;
        logic [3:0][1:0] need;
    } vec_t;

    vec_t       tbl [12];
    int         checks;
    int         failures;
    int         exp_sc [4];
    int         sc_max [4];
    int         first_b [4];
    int         tot_b [4];
    int         tot;
    logic [1:0] exp_q [$];

    hazard_ctl #(.CNT_W(16)) u_def (
        .clk(clk), .rst(rst), .id_vld(id_vld), .id_src_addr(id_src_addr), .id_src_vld(id_src_vld),
        .ex_dst_addr(ex_dst_addr), .mem_dst_addr(mem_dst_addr), .wb_dst_addr(wb_dst_addr),
        .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en), .ex_is_load(ex_is_load),
        .br_taken(br_taken), .ext_stall(ext_stall), .pc_hold(pc_hold_v[0]), .ifid_hold(ifid_hold_v[0]),
        .idex_bubble(idex_bubble_v[0]), .ifid_flush(ifid_flush_v[0]), .pipe_freeze(pipe_freeze_v[0]),
        .stall_cycles(sc_def), .dbg_state(dbg_state_v[0]), .dbg_cnt(dbg_cnt_v[0])
    );

    hazard_ctl #(.RF_BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .id_vld(id_vld), .id_src_addr(id_src_addr), .id_src_vld(id_src_vld),
        .ex_dst_addr(ex_dst_addr), .mem_dst_addr(mem_dst_addr), .wb_dst_addr(wb_dst_addr),
        .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en), .ex_is_load(ex_is_load),
        .br_taken(br_taken), .ext_stall(ext_stall), .pc_hold(pc_hold_v[1]), .ifid_hold(ifid_hold_v[1]),
        .idex_bubble(idex_bubble_v[1]), .ifid_flush(ifid_flush_v[1]), .pipe_freeze(pipe_freeze_v[1]),
        .stall_cycles(sc_nb), .dbg_state(dbg_state_v[1]), .dbg_cnt(dbg_cnt_v[1])
    );

    hazard_ctl #(.FWD_EN(1)) u_fwd (
        .clk(clk), .rst(rst), .id_vld(id_vld), .id_src_addr(id_src_addr), .id_src_vld(id_src_vld),
        .ex_dst_addr(ex_dst_addr), .mem_dst_addr(mem_dst_addr), .wb_dst_addr(wb_dst_addr),
        .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en), .ex_is_load(ex_is_load),
        .br_taken(br_taken), .ext_stall(ext_stall), .pc_hold(pc_hold_v[2]), .ifid_hold(ifid_hold_v[2]),
        .idex_bubble(idex_bubble_v[2]), .ifid_flush(ifid_flush_v[2]), .pipe_freeze(pipe_freeze_v[2]),
        .stall_cycles(sc_fwd), .dbg_state(dbg_state_v[2]), .dbg_cnt(dbg_cnt_v[2])
    );

    hazard_ctl #(.ZERO_REG(1), .CNT_W(Z_CNT_W)) u_z (
        .clk(clk), .rst(rst), .id_vld(id_vld), .id_src_addr(id_src_addr), .id_src_vld(id_src_vld),
        .ex_dst_addr(ex_dst_addr), .mem_dst_addr(mem_dst_addr), .wb_dst_addr(wb_dst_addr),
        .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en), .ex_is_load(ex_is_load),
        .br_taken(br_taken), .ext_stall(ext_stall), .pc_hold(pc_hold_v[3]), .ifid_hold(ifid_hold_v[3]),
        .idex_bubble(idex_bubble_v[3]), .ifid_flush(ifid_flush_v[3]), .pipe_freeze(pipe_freeze_v[3]),
        .stall_cycles(sc_z), .dbg_state(dbg_state_v[3]), .dbg_cnt(dbg_cnt_v[3])
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // Driver tasks.
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_vld = 1'b0; id_src_addr = '0; id_src_vld = '0;
        ex_dst_addr = '0; mem_dst_addr = '0; wb_dst_addr = '0;
        ex_wr_en = 1'b0; mem_wr_en = 1'b0; wb_wr_en = 1'b0; ex_is_load = 1'b0;
        br_taken = 1'b0; ext_stall = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        id_vld = v.vld; id_src_addr = {v.s1, v.s0}; id_src_vld = v.sv;
        ex_dst_addr = v.exd; mem_dst_addr = v.memd; wb_dst_addr = v.wbd;
        ex_wr_en = v.exw; mem_wr_en = v.memw; wb_wr_en = v.wbw; ex_is_load = v.ld;
        br_taken = 1'b0; ext_stall = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        for (int d = 0; d < 4; d++) exp_sc[d] = 0;
    endtask

    function automatic int get_sc(input int d);
        case (d)
            0:       return int'(sc_def);
            1:       return int'(sc_nb);
            2:       return int'(sc_fwd);
            default: return int'(sc_z);
        endcase
    endfunction

    function automatic vec_t mk(input logic vld, input logic [2:0] s0, input logic [2:0] s1,
                                input logic [1:0] sv, input logic [2:0] exd, input logic exw,
                                input logic [2:0] memd, input logic memw, input logic [2:0] wbd,
                                input logic wbw, input logic ld,
                                input int n0, input int n1, input int n2, input int n3);
        vec_t v;
        v.vld = vld; v.s0 = s0; v.s1 = s1; v.sv = sv;
        v.exd = exd; v.exw = exw; v.memd = memd; v.memw = memw; v.wbd = wbd; v.wbw = wbw; v.ld = ld;
        v.need[0] = 2'(n0); v.need[1] = 2'(n1); v.need[2] = 2'(n2); v.need[3] = 2'(n3);
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        sc_max   = '{65535, 65535, 65535, (1 << Z_CNT_W) - 1};
        for (int d = 0; d < 4; d++) exp_sc[d] = 0;

        //               vld s0 s1 sv     exd w  memd w  wbd w  ld   def nb fwd z
        tbl[0]  = mk(1, 3, 1, 2'b01, 3, 1, 6, 0, 4, 0, 0,  2, 3, 0, 2);
        tbl[1]  = mk(1, 3, 1, 2'b01, 3, 1, 6, 0, 4, 0, 1,  2, 3, 1, 2);
        tbl[2]  = mk(1, 2, 5, 2'b11, 2, 1, 5, 1, 4, 0, 0,  2, 3, 0, 2);
        tbl[3]  = mk(1, 4, 1, 2'b01, 3, 1, 6, 1, 4, 1, 0,  0, 1, 0, 0);
        tbl[4]  = mk(1, 0, 1, 2'b01, 0, 1, 6, 0, 4, 0, 0,  2, 3, 0, 0);
        tbl[5]  = mk(1, 6, 1, 2'b01, 3, 1, 6, 1, 4, 0, 0,  1, 2, 0, 1);
        tbl[6]  = mk(0, 3, 1, 2'b01, 3, 1, 6, 0, 4, 0, 0,  0, 0, 0, 0);
        tbl[7]  = mk(1, 3, 1, 2'b10, 3, 1, 6, 0, 4, 0, 0,  0, 0, 0, 0);
        tbl[8]  = mk(1, 3, 1, 2'b01, 3, 0, 3, 0, 3, 0, 0,  0, 0, 0, 0);
        tbl[9]  = mk(1, 7, 7, 2'b11, 7, 1, 7, 1, 7, 1, 1,  2, 3, 1, 2);
        tbl[10] = mk(1, 2, 1, 2'b11, 3, 1, 2, 1, 1, 1, 0,  1, 2, 0, 1);
        tbl[11] = mk(1, 5, 0, 2'b10, 5, 1, 0, 1, 4, 0, 0,  1, 2, 0, 0);

        // Reset: outputs quiet even with a live hazard and a taken branch present.
        rst = 1'b0;
        drive_vec(tbl[0]);
        br_taken = 1'b1;
        #3;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset_outputs_dut%0d", d),
                  {pc_hold_v[d], ifid_hold_v[d], idex_bubble_v[d], ifid_flush_v[d], pipe_freeze_v[d]}, 0);
        end
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset_state_dut%0d", d), dbg_state_v[d], 0);
            check($sformatf("reset_cnt_dut%0d", d), dbg_cnt_v[d], 0);
            check($sformatf("reset_sc_dut%0d", d), get_sc(d), 0);
        end
        rst = 1'b1;
        idle();
        next_cycle();

        // Vector table: one instruction in ID for a cycle, then drain.
        for (int r = 0; r < 12; r++) begin
            drive_vec(tbl[r]);
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                first_b[d] = int'(idex_bubble_v[d]);
                tot_b[d]   = int'(idex_bubble_v[d]);
                check($sformatf("row%0d_dut%0d_pc_hold", r, d), pc_hold_v[d], int'(tbl[r].need[d] != 0));
            end
            next_cycle();
            idle();
            repeat (3) begin
                @(negedge clk);
                for (int d = 0; d < 4; d++) tot_b[d] += int'(idex_bubble_v[d]);
                next_cycle();
            end
            for (int d = 0; d < 4; d++) begin
                check($sformatf("row%0d_dut%0d_first", r, d), first_b[d], int'(tbl[r].need[d] != 0));
                check($sformatf("row%0d_dut%0d_bubbles", r, d), tot_b[d], int'(tbl[r].need[d]));
                exp_sc[d] = exp_sc[d] + int'(tbl[r].need[d]);
                if (exp_sc[d] > sc_max[d]) exp_sc[d] = sc_max[d];
            end
        end
        @(negedge clk);
        for (int d = 0; d < 4; d++) check($sformatf("table_sc_dut%0d", d), get_sc(d), exp_sc[d]);
        next_cycle();

        // Back-to-back: next dependency is evaluated on the first RUN cycle.
        do_reset();
        drive_vec(tbl[0]);
        @(negedge clk);
        check("b2b_c1_bubble", idex_bubble_v[0], 1);
        check("b2b_c1_state", dbg_state_v[0], 0);
        next_cycle();
        @(negedge clk);
        check("b2b_c2_bubble", idex_bubble_v[0], 1);
        check("b2b_c2_state", dbg_state_v[0], 1);
        check("b2b_c2_cnt", dbg_cnt_v[0], 1);
        next_cycle();
        drive_vec(tbl[5]);
        @(negedge clk);
        check("b2b_c3_bubble", idex_bubble_v[0], 1);
        check("b2b_c3_state", dbg_state_v[0], 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("b2b_c4_bubble", idex_bubble_v[0], 0);
        check("b2b_sc", sc_def, int'(tbl[0].need[0]) + int'(tbl[5].need[0]));
        next_cycle();

        // Taken branch aborts a stall in progress (no-bypass variant, cnt=2).
        do_reset();
        drive_vec(tbl[0]);
        @(negedge clk);
        check("br_c1_bubble", idex_bubble_v[1], 1);
        next_cycle();
        idle();
        br_taken = 1'b1;
        @(negedge clk);
        check("br_c2_state", dbg_state_v[1], 1);
        check("br_c2_cnt", dbg_cnt_v[1], 2);
        check("br_c2_flush", ifid_flush_v[1], 1);
        check("br_c2_bubble", idex_bubble_v[1], 1);
        check("br_c2_pc_hold", pc_hold_v[1], 0);
        check("br_c2_ifid_hold", ifid_hold_v[1], 0);
        next_cycle();
        br_taken = 1'b0;
        @(negedge clk);
        check("br_c3_state", dbg_state_v[1], 0);
        check("br_c3_cnt", dbg_cnt_v[1], 0);
        check("br_c3_pc_hold", pc_hold_v[1], 0);
        check("br_c3_bubble", idex_bubble_v[1], 0);
        check("br_sc", sc_nb, 2);
        next_cycle();

        // External freeze during STALL holds everything, then the stall resumes.
        do_reset();
        drive_vec(tbl[0]);
        next_cycle();
        idle();
        ext_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("frz%0d_freeze", k), pipe_freeze_v[1], 1);
            check($sformatf("frz%0d_pc_hold", k), pc_hold_v[1], 1);
            check($sformatf("frz%0d_ifid_hold", k), ifid_hold_v[1], 1);
            check($sformatf("frz%0d_bubble", k), idex_bubble_v[1], 0);
            check($sformatf("frz%0d_flush", k), ifid_flush_v[1], 0);
            check($sformatf("frz%0d_state", k), dbg_state_v[1], 1);
            check($sformatf("frz%0d_cnt", k), dbg_cnt_v[1], 2);
            check($sformatf("frz%0d_sc", k), sc_nb, 1);
            next_cycle();
        end
        ext_stall = 1'b0;
        tot = 0;
        repeat (3) begin
            @(negedge clk);
            tot += int'(idex_bubble_v[1]);
            next_cycle();
        end
        check("frz_resume_bubbles", tot, 2);
        @(negedge clk);
        check("frz_end_state", dbg_state_v[1], 0);
        check("frz_end_sc", sc_nb, 3);
        next_cycle();

        // Freeze and branch together: freeze wins, flush follows once freeze drops.
        do_reset();
        br_taken  = 1'b1;
        ext_stall = 1'b1;
        @(negedge clk);
        check("brfrz_c1_freeze", pipe_freeze_v[0], 1);
        check("brfrz_c1_flush", ifid_flush_v[0], 0);
        check("brfrz_c1_bubble", idex_bubble_v[0], 0);
        check("brfrz_c1_pc_hold", pc_hold_v[0], 1);
        next_cycle();
        ext_stall = 1'b0;
        @(negedge clk);
        check("brfrz_c2_freeze", pipe_freeze_v[0], 0);
        check("brfrz_c2_flush", ifid_flush_v[0], 1);
        check("brfrz_c2_bubble", idex_bubble_v[0], 1);
        check("brfrz_c2_pc_hold", pc_hold_v[0], 0);
        next_cycle();
        br_taken = 1'b0;
        @(negedge clk);
        check("brfrz_c3_flush", ifid_flush_v[0], 0);
        check("brfrz_sc", sc_def, 1);
        next_cycle();

        // Asynchronous reset in the middle of a STALL.
        do_reset();
        drive_vec(tbl[0]);
        next_cycle();
        #2;
        rst = 1'b0;
        #1;
        check("arst_state", dbg_state_v[1], 0);
        check("arst_cnt", dbg_cnt_v[1], 0);
        check("arst_bubble", idex_bubble_v[1], 0);
        check("arst_pc_hold", pc_hold_v[1], 0);
        check("arst_sc", sc_nb, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_rel_bubble", idex_bubble_v[1], 1);
        check("arst_rel_state", dbg_state_v[1], 0);
        next_cycle();
        check("arst_edge_state", dbg_state_v[1], 1);
        check("arst_edge_cnt", dbg_cnt_v[1], 2);
        idle();
        repeat (3) next_cycle();

        // Saturation of the 2-bit counter variant.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp_sc[3] = exp_sc[3] + int'(tbl[0].need[3]);
            if (exp_sc[3] > sc_max[3]) exp_sc[3] = sc_max[3];
            exp_q.push_back(2'(exp_sc[3]));
        end
        for (int k = 0; k < 3; k++) begin
            drive_vec(tbl[0]);
            next_cycle();
            idle();
            repeat (3) next_cycle();
            @(negedge clk);
            check($sformatf("sat%0d_sc", k), sc_z, int'(exp_q.pop_front()));
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
